// File: rtl/srv_mem_arb.sv
// Two-requester round-robin arbiter feeding a single-outstanding memory port with a watchdog.
// Latency: request seen in IDLE -> ext_req_o next cycle; ext_rsp_i -> requester rsp pulse next cycle.
// Backpressure: losers hold their req level; a held req is re-arbitrated after one IDLE cycle.
module srv_mem_arb #(
   parameter int TIMEOUT = 64,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req_i,
   input  logic [AW-1:0] m0_addr_i,
   output logic          m0_rsp_o,
   input  logic          m1_req_i,
   input  logic [AW-1:0] m1_addr_i,
   output logic          m1_rsp_o,
   output logic [127:0]  rsp_data_o,
   output logic          rsp_err_o,
   output logic          ext_req_o,
   output logic [AW-1:0] ext_addr_o,
   input  logic          ext_rsp_i,
   input  logic [127:0]  ext_data_i
);

   // Counter wide enough to reach TIMEOUT; a 1-bit stub when the watchdog is disabled.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic            win_q, win_d;       // 0 = m0, 1 = m1
   logic            last_q, last_d;     // requester granted most recently
   logic [AW-1:0]   addr_q, addr_d;
   logic            ext_req_q, ext_req_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            m0_rsp_q, m0_rsp_d;
   logic            m1_rsp_q, m1_rsp_d;
   logic [127:0]    data_q, data_d;
   logic            err_q, err_d;

   logic            gnt;
   logic            wd_fire;

   // On a tie the requester not served last wins; otherwise whoever asks.
   assign gnt     = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
   assign wd_fire = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

   // Next-state and output computation; response beats the watchdog on the same edge.
   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      last_d    = last_q;
      addr_d    = addr_q;
      ext_req_d = ext_req_q;
      cnt_d     = cnt_q;
      m0_rsp_d  = 1'b0;
      m1_rsp_d  = 1'b0;
      data_d    = data_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (m0_req_i || m1_req_i) begin
               win_d     = gnt;
               last_d    = gnt;
               addr_d    = gnt ? m1_addr_i : m0_addr_i;
               cnt_d     = '0;
               ext_req_d = 1'b1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (ext_rsp_i) begin
               data_d    = ext_data_i;
               err_d     = 1'b0;
               m0_rsp_d  = ~win_q;
               m1_rsp_d  = win_q;
               ext_req_d = 1'b0;
               state_d   = IDLE;
            end else if (wd_fire) begin
               data_d    = '0;
               err_d     = 1'b1;
               m0_rsp_d  = ~win_q;
               m1_rsp_d  = win_q;
               ext_req_d = 1'b0;
               state_d   = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            ext_req_d = 1'b0;
         end
      endcase
   end

   // State register; reset drops any in-flight transfer and favours m0 on the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         win_q     <= 1'b0;
         last_q    <= 1'b1;
         addr_q    <= '0;
         ext_req_q <= 1'b0;
         cnt_q     <= '0;
         m0_rsp_q  <= 1'b0;
         m1_rsp_q  <= 1'b0;
         data_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         ext_req_q <= ext_req_d;
         cnt_q     <= cnt_d;
         m0_rsp_q  <= m0_rsp_d;
         m1_rsp_q  <= m1_rsp_d;
         data_q    <= data_d;
         err_q     <= err_d;
      end
   end

   assign ext_req_o  = ext_req_q;
   assign ext_addr_o = addr_q;
   assign m0_rsp_o   = m0_rsp_q;
   assign m1_rsp_o   = m1_rsp_q;
   assign rsp_data_o = data_q;
   assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_srv_mem_arb.sv
// Directed bench for srv_mem_arb with a short watchdog (TIMEOUT=4).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-computed constants.
module tb_srv_mem_arb;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_req_i, m1_req_i;
   logic [AW-1:0] m0_addr_i, m1_addr_i;
   logic          m0_rsp_o, m1_rsp_o;
   logic [127:0]  rsp_data_o;
   logic          rsp_err_o;
   logic          ext_req_o;
   logic [AW-1:0] ext_addr_o;
   logic          ext_rsp_i;
   logic [127:0]  ext_data_i;

   int n_checks = 0;
   int n_errors = 0;

   srv_mem_arb #(.TIMEOUT(4), .AW(AW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m0_req_i   (m0_req_i),
      .m0_addr_i  (m0_addr_i),
      .m0_rsp_o   (m0_rsp_o),
      .m1_req_i   (m1_req_i),
      .m1_addr_i  (m1_addr_i),
      .m1_rsp_o   (m1_rsp_o),
      .rsp_data_o (rsp_data_o),
      .rsp_err_o  (rsp_err_o),
      .ext_req_o  (ext_req_o),
      .ext_addr_o (ext_addr_o),
      .ext_rsp_i  (ext_rsp_i),
      .ext_data_i (ext_data_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Check the pulse state and data outputs together.
   task automatic chk_rsp(input string tag, input logic e0, input logic e1,
                          input logic [127:0] edat, input logic eerr, input logic ereq);
      chk({tag, ".m0_rsp"}, 128'(m0_rsp_o), 128'(e0));
      chk({tag, ".m1_rsp"}, 128'(m1_rsp_o), 128'(e1));
      chk({tag, ".data"},   rsp_data_o, edat);
      chk({tag, ".err"},    128'(rsp_err_o), 128'(eerr));
      chk({tag, ".ext_req"}, 128'(ext_req_o), 128'(ereq));
   endtask

   // At a falling edge in BUSY: verify the request, answer it, and check the pulse.
   task automatic serve(input string tag, input logic who, input logic [AW-1:0] eaddr,
                        input logic [127:0] dat, input logic drop_reqs);
      chk({tag, ".ext_req"},  128'(ext_req_o), 128'd1);
      chk({tag, ".ext_addr"}, 128'(ext_addr_o), 128'(eaddr));
      chk({tag, ".no_early"}, 128'(m0_rsp_o | m1_rsp_o), 128'd0);
      ext_rsp_i  = 1'b1;
      ext_data_i = dat;
      tick();
      ext_rsp_i  = 1'b0;
      ext_data_i = '0;
      if (drop_reqs) begin
         m0_req_i = 1'b0;
         m1_req_i = 1'b0;
      end
      chk_rsp({tag, ".pulse"}, ~who, who, dat, 1'b0, 1'b0);
      tick();
   endtask

   localparam logic [127:0] D_A    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] D_B    = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234;
   localparam logic [127:0] D_C    = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
   localparam logic [127:0] D_DEAD = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
   localparam logic [127:0] D_E    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] D_X    = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

   initial begin
      rst_n      = 1'b0;
      m0_req_i   = 1'b0;
      m1_req_i   = 1'b0;
      m0_addr_i  = '0;
      m1_addr_i  = '0;
      ext_rsp_i  = 1'b0;
      ext_data_i = '0;
      tick();
      tick();
      chk_rsp("reset", 1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
      chk("reset.ext_addr", 128'(ext_addr_o), 128'd0);
      rst_n = 1'b1;
      tick();

      // Tie from reset: m0, m1, m0.
      m0_req_i  = 1'b1; m0_addr_i = 32'h100;
      m1_req_i  = 1'b1; m1_addr_i = 32'h200;
      tick();
      serve("rr0", 1'b0, 32'h100, D_A, 1'b0);
      serve("rr1", 1'b1, 32'h200, D_B, 1'b0);
      serve("rr2", 1'b0, 32'h100, D_C, 1'b1);
      chk_rsp("rr.idle", 1'b0, 1'b0, D_C, 1'b0, 1'b0);

      // m1 alone, response 3 cycles after ext_req rises; req drop and addr change mid-BUSY.
      m1_req_i = 1'b1; m1_addr_i = 32'h300;
      tick();
      chk("m1.ext_req", 128'(ext_req_o), 128'd1);
      chk("m1.addr0", 128'(ext_addr_o), 128'h300);
      m1_req_i = 1'b0; m1_addr_i = 32'hABC;
      tick();
      chk("m1.addr1", 128'(ext_addr_o), 128'h300);
      chk("m1.busy1", 128'(ext_req_o), 128'd1);
      chk("m1.nopulse", 128'(m1_rsp_o), 128'd0);
      tick();
      ext_rsp_i = 1'b1; ext_data_i = D_DEAD;
      tick();
      ext_rsp_i = 1'b0; ext_data_i = '0;
      chk_rsp("m1.pulse", 1'b0, 1'b1, D_DEAD, 1'b0, 1'b0);
      tick();
      chk_rsp("m1.hold", 1'b0, 1'b0, D_DEAD, 1'b0, 1'b0);

      // Watchdog abort after 4 BUSY cycles.
      m0_req_i = 1'b1; m0_addr_i = 32'h400;
      tick();
      m0_req_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_rsp($sformatf("wd.busy%0d", i), 1'b0, 1'b0, D_DEAD, 1'b0, 1'b1);
         tick();
      end
      chk_rsp("wd.abort", 1'b1, 1'b0, 128'd0, 1'b1, 1'b0);
      tick();
      chk_rsp("wd.hold", 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);

      // Response on the timeout edge wins.
      m0_req_i = 1'b1; m0_addr_i = 32'h500;
      tick();
      m0_req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_rsp($sformatf("race.busy%0d", i), 1'b0, 1'b0, 128'd0, 1'b1, 1'b1);
         tick();
      end
      ext_rsp_i = 1'b1; ext_data_i = D_E;
      tick();
      ext_rsp_i = 1'b0; ext_data_i = '0;
      chk_rsp("race.pulse", 1'b1, 1'b0, D_E, 1'b0, 1'b0);
      tick();

      // Stray response while IDLE is ignored.
      ext_rsp_i = 1'b1; ext_data_i = D_X;
      tick();
      ext_rsp_i = 1'b0; ext_data_i = '0;
      chk_rsp("stray", 1'b0, 1'b0, D_E, 1'b0, 1'b0);
      tick();
      chk_rsp("stray2", 1'b0, 1'b0, D_E, 1'b0, 1'b0);

      // Reset mid-BUSY: outputs clear at once and no pulse follows.
      m1_req_i = 1'b1; m1_addr_i = 32'h600;
      tick();
      chk("rst.busy", 128'(ext_req_o), 128'd1);
      chk("rst.addr", 128'(ext_addr_o), 128'h600);
      #2 rst_n = 1'b0;
      #1;
      chk_rsp("rst.async", 1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
      chk("rst.async_addr", 128'(ext_addr_o), 128'd0);
      m1_req_i = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_rsp($sformatf("rst.after%0d", i), 1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
      end

      // Round-robin pointer restored by reset: m0 wins the next tie.
      m0_req_i = 1'b1; m0_addr_i = 32'h700;
      m1_req_i = 1'b1; m1_addr_i = 32'h800;
      tick();
      serve("tie2", 1'b0, 32'h700, D_A, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/srv_mem_arb.md
SRV_MEM_ARB -- requirements
Module: srv_mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles BUSY may last before abort; 0 disables the watchdog.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m0_req_i  input  1  requester 0 (icache refill) request level.
REQ-006 m0_addr_i  input  AW  requester 0 line address.
REQ-007 m0_rsp_o  output  1  requester 0 one-cycle completion pulse.
REQ-008 m1_req_i  input  1  requester 1 (data/debug loader) request level.
REQ-009 m1_addr_i  input  AW  requester 1 line address.
REQ-010 m1_rsp_o  output  1  requester 1 one-cycle completion pulse.
REQ-011 rsp_data_o  output  128  shared line data, valid while either rsp pulse is high.
REQ-012 rsp_err_o  output  1  high with a rsp pulse when the transfer was aborted by the watchdog.
REQ-013 ext_req_o  output  1  request level to memory controller.
REQ-014 ext_addr_o  output  AW  address to memory controller.
REQ-015 ext_rsp_i  input  1  memory controller completion pulse.
REQ-016 ext_data_i  input  128  memory controller line data, valid with ext_rsp_i.

Function
REQ-017 FSM states: IDLE, BUSY; the block SHALL keep at most one outstanding memory transfer.
REQ-018 IDLE: if any mX_req_i=1, the block SHALL latch the winner ID and its address, load cnt=0, and enter BUSY next edge.
REQ-019 Arbitration: single requester wins outright; both requesting -> the one not granted last (round-robin pointer `last`); `last` updates on every grant.
REQ-020 ext_req_o SHALL be a registered output: high throughout BUSY, low in IDLE; ext_addr_o SHALL hold the latched address, stable for the whole of BUSY.
REQ-021 Latency: request sampled in IDLE at edge N -> ext_req_o=1 after edge N.
REQ-022 BUSY + ext_rsp_i=1 at edge M: register ext_data_i into rsp_data_o, pulse rsp of latched winner for exactly one cycle after edge M, rsp_err_o=0, return to IDLE.
REQ-023 BUSY, each edge without ext_rsp_i: cnt SHALL increment (saturating width ceil(log2(TIMEOUT+1))).
REQ-024 Watchdog (TIMEOUT>0): BUSY with cnt==TIMEOUT-1 and ext_rsp_i=0 -> the block SHALL abort: winner's rsp pulse with rsp_err_o=1, rsp_data_o=0, enter IDLE.
REQ-025 Simultaneous ext_rsp_i and timeout edge: the response SHALL win (err=0, data captured).
REQ-026 ext_rsp_i while IDLE SHALL be ignored (no rsp pulse, no state change).
REQ-027 A requester deasserting req mid-BUSY SHALL NOT cancel the transfer; its rsp pulse is still issued.
REQ-028 A requester holding req after its rsp pulse is a new request; it is re-arbitrated in the following IDLE cycle, so back-to-back transfers are spaced by one IDLE cycle minimum.
REQ-029 Address changes on mX_addr_i during BUSY SHALL NOT affect ext_addr_o.
REQ-030 m0_rsp_o and m1_rsp_o SHALL never be high in the same cycle.
REQ-031 rsp_data_o and rsp_err_o SHALL hold their last value between pulses.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state=IDLE, ext_req_o=0, ext_addr_o=0, m0_rsp_o=0, m1_rsp_o=0, rsp_data_o=0, rsp_err_o=0, cnt=0, last=1 (m0 wins the first tie).
REQ-033 Reset asserted during BUSY SHALL drop the transfer silently: no rsp pulse is issued for it after release.

Verification
REQ-034 Both req_i=1 from reset (m0 addr 0x100, m1 addr 0x200) -> grant order m0, m1, m0; ext_addr_o 0x100, 0x200, 0x100; one rsp pulse per transfer.
REQ-035 m1 alone, ext_rsp_i 3 cycles after ext_req_o rises with data 0xDEADBEEF_...0001 -> m1_rsp_o pulse 1 cycle later, rsp_data_o matches, rsp_err_o=0.
REQ-036 TIMEOUT=4, ext_rsp_i never asserted -> after 4 BUSY cycles, m0_rsp_o=1, rsp_err_o=1, rsp_data_o=0, ext_req_o=0.
REQ-037 TIMEOUT=4, ext_rsp_i on the 4th BUSY cycle -> rsp_err_o=0, data captured.
REQ-038 Stray ext_rsp_i in IDLE, then rst_n low mid-BUSY -> no rsp pulses; all outputs 0 immediately on rst_n falling.
